// File: rtl/pool_pkg.sv
// Shared constants, activation type and pass FSM encoding for the pooling stages.
package pool_pkg;
  localparam int DATA_W  = 16;
  localparam int OUT_DIM = 12;
  localparam int N_OUT   = OUT_DIM * OUT_DIM;

  typedef logic signed [DATA_W-1:0] act_t;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
endpackage

// File: rtl/pool1_max_write_if.sv
// Read-window bus from the conv1 addresser plus the pool1 RAM write port.
interface pool1_max_write_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic                     rd_en;
  logic signed [DATA_W-1:0] rd_data0;
  logic signed [DATA_W-1:0] rd_data1;
  logic signed [DATA_W-1:0] rd_data2;
  logic signed [DATA_W-1:0] rd_data3;
  logic                     wr_en;
  logic        [ADDR_W-1:0] wr_addr;
  logic signed [DATA_W-1:0] wr_data;

  modport master (
    output rd_en,
    input  rd_data0, rd_data1, rd_data2, rd_data3,
    output wr_en, wr_addr, wr_data
  );

  modport slave (
    input  rd_en,
    output rd_data0, rd_data1, rd_data2, rd_data3,
    input  wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/max4_pipe.sv
// Two-stage signed max of four words with a travelling valid bit.
module max4_pipe #(
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_vld,
  input  logic signed [W-1:0] d0,
  input  logic signed [W-1:0] d1,
  input  logic signed [W-1:0] d2,
  input  logic signed [W-1:0] d3,
  output logic                out_vld,
  output logic signed [W-1:0] out_max
);
  logic [2:0]          vld_pipe;
  logic signed [W-1:0] m01, m23;

  assign vld_pipe[0] = in_vld;
  assign out_vld     = vld_pipe[2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe[2:1] <= '0;
      m01           <= '0;
      m23           <= '0;
      out_max       <= '0;
    end else begin
      vld_pipe[2:1] <= vld_pipe[1:0];
      if (vld_pipe[0]) begin
        m01 <= (d0 > d1) ? d0 : d1;
        m23 <= (d2 > d3) ? d2 : d3;
      end
      if (vld_pipe[1])
        out_max <= (m01 > m23) ? m01 : m23;
    end
  end
endmodule

// File: rtl/pool1_max_write.sv
// Pool1 pass controller: issues 144 window reads, max-pools each window and
// writes the 12x12 result linearly into the pool1 RAM.
module pool1_max_write #(
  parameter int DATA_W  = pool_pkg::DATA_W,
  parameter int OUT_DIM = pool_pkg::OUT_DIM,
  parameter int ADDR_W  = 8,
  parameter int RD_LAT  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  pool1_max_write_if.master bus,
  output logic              busy,
  output logic              done
);
  import pool_pkg::*;

  localparam int N_OUT = OUT_DIM * OUT_DIM;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_OUT - 1);

  state_t            state, nxt;
  logic [ADDR_W-1:0] issue_cnt;
  logic [ADDR_W-1:0] wr_addr;
  logic [RD_LAT:0]   vld_pipe;

  assign bus.rd_en   = (state == ISSUE);
  assign busy        = (state == ISSUE) || (state == DRAIN);
  assign done        = (state == DONE);
  assign bus.wr_addr = wr_addr;
  assign vld_pipe[0] = bus.rd_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      issue_cnt <= '0;
      wr_addr   <= '0;
      vld_pipe[RD_LAT:1] <= '0;
    end else begin
      state <= nxt;
      vld_pipe[RD_LAT:1] <= vld_pipe[RD_LAT-1:0];
      if (state == ISSUE)
        issue_cnt <= issue_cnt + 1'b1;
      // address parks on the last slot so the pass never wraps
      if (bus.wr_en && wr_addr != LAST)
        wr_addr <= wr_addr + 1'b1;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = ISSUE;
      ISSUE:   if (issue_cnt == LAST) nxt = DRAIN;
      DRAIN:   if (bus.wr_en && wr_addr == LAST) nxt = DONE;
      DONE:    nxt = DONE;
      default: nxt = IDLE;
    endcase
  end

  max4_pipe #(.W(DATA_W)) u_max (
    .clk     (clk),
    .reset   (reset),
    .in_vld  (vld_pipe[RD_LAT]),
    .d0      (bus.rd_data0),
    .d1      (bus.rd_data1),
    .d2      (bus.rd_data2),
    .d3      (bus.rd_data3),
    .out_vld (bus.wr_en),
    .out_max (bus.wr_data)
  );
endmodule
